// File: rtl/lsu_ctrl.sv
// lsu_ctrl: load/store sequencer between the RV32I execute stage and a
// word-organised data memory. It takes one request at a time, validates
// funct3, alignment and address range, and drives a single-cycle memory access.
// Loads are lane-extracted and extended. The result is returned through a
// valid/ready response handshake.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   req_valid/req_ready      request handshake
//   req_we, req_funct3       1 = store / 0 = load, RV32I funct3
//   req_addr, req_wdata      byte address, right-justified store data
//   resp_valid/resp_ready    response handshake
//   resp_rdata, resp_err     extended load data (0 for stores/errors), reject flag
//   mem_addr, mem_wdata      word index, lane-replicated store data
//   mem_wr, mem_mask         one-cycle write strobe, byte-lane enables
//   mem_rdata                combinational read word for mem_addr
module lsu_ctrl #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              mem_wr,
  output logic [3:0]        mem_mask,
  input  logic [31:0]       mem_rdata
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t              state_q, state_d;
  logic                init_q;
  logic                we_q, we_d;
  logic [2:0]          funct3_q, funct3_d;
  logic [1:0]          off_q, off_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [31:0]         mem_wdata_q, mem_wdata_d;
  logic [3:0]          mem_mask_q, mem_mask_d;
  logic                mem_wr_q, mem_wr_d;
  logic                resp_valid_q, resp_valid_d;
  logic [31:0]         resp_rdata_q, resp_rdata_d;
  logic                resp_err_q, resp_err_d;
  logic                accept;

  function automatic logic req_bad(input logic we, input logic [2:0] f3,
                                   input logic [31:0] addr);
    logic bad_f3, bad_align, bad_range;
    bad_f3    = we ? (f3 > 3'b010)
                   : !(f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    // f3[1:0] encodes the access size: 01 = half, 10 = word.
    bad_align = ((f3[1:0] == 2'b01) && addr[0]) ||
                ((f3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
    bad_range = (addr >> (ADDR_W + 2)) != 32'd0;
    return bad_f3 || bad_align || bad_range;
  endfunction

  function automatic logic [3:0] store_mask(input logic [2:0] f3, input logic [1:0] off);
    case (f3[1:0])
      2'b00:   return 4'b0001 << off;
      2'b01:   return off[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [31:0] w);
    case (f3[1:0])
      2'b00:   return {4{w[7:0]}};
      2'b01:   return {2{w[15:0]}};
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] load_ext(input logic [2:0] f3, input logic [1:0] off,
                                          input logic [31:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{off, 3'b000} +: 8];
    h = word[{off[1], 4'b0000} +: 16];
    case (f3)
      3'b000:  return {{24{b[7]}}, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b100:  return {24'd0, b};
      3'b101:  return {16'd0, h};
      default: return word;
    endcase
  endfunction

  // init_q keeps req_ready low during the first cycle after reset.
  assign req_ready = (state_q == IDLE) && !rst && !init_q;
  assign accept    = req_valid && req_ready;

  always_comb begin
    state_d      = state_q;
    we_d         = we_q;
    funct3_d     = funct3_q;
    off_d        = off_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_mask_d   = mem_mask_q;
    mem_wr_d     = mem_wr_q;
    resp_valid_d = resp_valid_q;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          we_d     = req_we;
          funct3_d = req_funct3;
          off_d    = req_addr[1:0];
          if (req_bad(req_we, req_funct3, req_addr)) begin
            state_d      = RESP;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
            resp_rdata_d = 32'd0;
          end else begin
            state_d     = ACCESS;
            mem_addr_d  = req_addr[ADDR_W+1:2];
            mem_mask_d  = store_mask(req_funct3, req_addr[1:0]);
            mem_wdata_d = store_data(req_funct3, req_wdata);
            mem_wr_d    = req_we;
          end
        end
      end
      ACCESS: begin
        state_d      = RESP;
        mem_addr_d   = '0;
        mem_mask_d   = 4'd0;
        mem_wdata_d  = 32'd0;
        mem_wr_d     = 1'b0;
        resp_valid_d = 1'b1;
        resp_err_d   = 1'b0;
        resp_rdata_d = we_q ? 32'd0 : load_ext(funct3_q, off_q, mem_rdata);
      end
      RESP: begin
        if (resp_ready) begin
          state_d      = IDLE;
          resp_valid_d = 1'b0;
          resp_err_d   = 1'b0;
          resp_rdata_d = 32'd0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      init_q       <= 1'b1;
      we_q         <= 1'b0;
      funct3_q     <= 3'd0;
      off_q        <= 2'd0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= 32'd0;
      mem_mask_q   <= 4'd0;
      mem_wr_q     <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 32'd0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      init_q       <= 1'b0;
      we_q         <= we_d;
      funct3_q     <= funct3_d;
      off_q        <= off_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_mask_q   <= mem_mask_d;
      mem_wr_q     <= mem_wr_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
    end
  end

  // Outputs are forced low while rst is high so a reset landing in ACCESS
  // cannot produce a partial write and a pending response disappears at once.
  assign mem_addr   = rst ? '0    : mem_addr_q;
  assign mem_wdata  = rst ? 32'd0 : mem_wdata_q;
  assign mem_mask   = rst ? 4'd0  : mem_mask_q;
  assign mem_wr     = mem_wr_q && !rst;
  assign resp_valid = resp_valid_q && !rst;
  assign resp_rdata = rst ? 32'd0 : resp_rdata_q;
  assign resp_err   = resp_err_q && !rst;

endmodule
